// File: rtl/ppl_io_port_pkg.sv
// ppl_io_port_pkg: shared I/O address map for the memory-stage I/O responder.
package ppl_io_port_pkg;
`include "ppl_io_defs.vh"
    typedef logic [4:0] io_idx_t;
endpackage

// File: rtl/ppl_io_port_if.sv
// ppl_io_port_if: memory-stage bus seen by the I/O responder.
interface ppl_io_port_if;
    logic mWriteMem;
    logic [31:0] mAlu;
    logic [31:0] mDataB;
    logic [31:0] ioOut;
    modport master(output mWriteMem, mAlu, mDataB, input ioOut);
    modport slave(input mWriteMem, mAlu, mDataB, output ioOut);
endinterface

// File: rtl/ppl_io_defs.vh
// ppl_io_defs.vh: I/O word indices and the address bit that selects the I/O block.
localparam int IO_SEL_BIT = 7;
localparam logic [4:0] IO_SW = 5'd0;
localparam logic [4:0] IO_KEY = 5'd1;
localparam logic [4:0] IO_KEY_EDGE = 5'd2;
localparam logic [4:0] IO_LED = 5'd3;
localparam logic [4:0] IO_HEX = 5'd4;
localparam logic [4:0] IO_TICKS = 5'd5;

// File: rtl/ppl_sevenseg.sv
// ppl_sevenseg: 4-bit to active-low 7-segment (gfedcba) hex decoder.
module ppl_sevenseg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/ppl_io_port.sv
// ppl_io_port: memory-mapped board I/O (switches, keys, LEDs, hex digits, tick counter).
// Define PPL_IO_DEBOUNCE_EN to add per-key debounce counters.
module ppl_io_port import ppl_io_port_pkg::*; #(
    parameter int SW_W = 10,
    parameter int KEY_N = 4,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    ppl_io_port_if.slave bus,
    input  logic [SW_W-1:0] sw,
    input  logic [KEY_N-1:0] key,
    output logic [SW_W-1:0] led,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);
    io_idx_t idx;
    logic wr;
    logic [KEY_N-1:0] key_in, key_s1, key_s2, key_deb, key_deb_q, armed, key_edge;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic [1:0] sync_ok;
    logic [23:0] hex_r;
    logic [31:0] ticks;
    logic [6:0] seg [6];
    logic unused;
    assign idx = bus.mAlu[6:2];
    assign wr = bus.mWriteMem & bus.mAlu[IO_SEL_BIT];
    assign key_in = (KEY_ACTIVE_LOW != 0) ? ~key : key;
    assign unused = ^{bus.mAlu[31:8], bus.mAlu[1:0], bus.mDataB[31:24]};
    // armed marks keys seen released since reset, so a key held through reset raises no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
            sync_ok <= '0;
            key_deb_q <= '0;
            armed <= '0;
            key_edge <= '0;
            led <= '0;
            hex_r <= '0;
            ticks <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            key_s1 <= key_in;
            key_s2 <= key_s1;
            sync_ok <= {sync_ok[0], 1'b1};
            key_deb_q <= key_deb;
            armed <= armed | (sync_ok[1] ? ~key_s2 : '0);
            key_edge <= (key_edge & ~((wr && idx == IO_KEY_EDGE) ? bus.mDataB[KEY_N-1:0] : '0))
                        | (key_deb & ~key_deb_q & armed);
            led <= (wr && idx == IO_LED) ? bus.mDataB[SW_W-1:0] : led;
            hex_r <= (wr && idx == IO_HEX) ? bus.mDataB[23:0] : hex_r;
            ticks <= (wr && idx == IO_TICKS) ? '0 : ticks + 32'd1;
        end
    end
`ifdef PPL_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    for (genvar i = 0; i < KEY_N; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic deb;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                deb <= 1'b0;
            end else if (key_s2[i] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                deb <= key_s2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign key_deb[i] = deb;
    end
`else
    assign key_deb = key_s2;
`endif
    always_comb begin
        case (idx)
            IO_SW: bus.ioOut = 32'(sw_s2);
            IO_KEY: bus.ioOut = 32'(key_deb);
            IO_KEY_EDGE: bus.ioOut = 32'(key_edge);
            IO_LED: bus.ioOut = 32'(led);
            IO_HEX: bus.ioOut = {8'h00, hex_r};
            IO_TICKS: bus.ioOut = ticks;
            default: bus.ioOut = '0;
        endcase
    end
    for (genvar d = 0; d < 6; d++) begin : g_hex
        ppl_sevenseg u_seg (.nib(hex_r[4*d +: 4]), .seg(seg[d]));
    end
    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];
endmodule

// File: tb/tb_ppl_io_port.sv
// tb_ppl_io_port: directed self-checking bench for ppl_io_port.
module tb_ppl_io_port;
    logic clk = 1'b0;
    logic rst;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] led;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [31:0] rv;
    int checks = 0;
    int failures = 0;

    ppl_io_port_if bus ();

    ppl_io_port #(.SW_W(10), .KEY_N(4), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw(sw), .key(key), .led(led),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_io(input logic [31:0] a, input logic [31:0] d);
        bus.mAlu = a;
        bus.mDataB = d;
        bus.mWriteMem = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mWriteMem = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.mAlu = a;
        #1 d = bus.ioOut;
    endtask

    task automatic test_reset;
        checks++; if (led !== 10'h000) begin failures++; $display("FAIL reset_led got=%h exp=%h", led, 10'h000); end
        checks++; if (hex0 !== 7'b1000000) begin failures++; $display("FAIL reset_hex0 got=%b exp=%b", hex0, 7'b1000000); end
        checks++; if (hex5 !== 7'b1000000) begin failures++; $display("FAIL reset_hex5 got=%b exp=%b", hex5, 7'b1000000); end
        rd(32'h94, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL reset_ticks got=%h exp=%h", rv, 32'h0); end
        rd(32'h88, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL reset_key_edge got=%h exp=%h", rv, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_led;
        wr_io(32'h8C, 32'h3FF);
        checks++; if (led !== 10'h3FF) begin failures++; $display("FAIL led_write got=%h exp=%h", led, 10'h3FF); end
        rd(32'h8C, rv);
        checks++; if (rv !== 32'h3FF) begin failures++; $display("FAIL led_read got=%h exp=%h", rv, 32'h3FF); end
        wr_io(32'h0C, 32'h0);
        checks++; if (led !== 10'h3FF) begin failures++; $display("FAIL led_nosel got=%h exp=%h", led, 10'h3FF); end
        wr_io(32'h98, 32'hFFFF_FFFF);
        rd(32'h98, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", rv, 32'h0); end
    endtask

    task automatic test_hex;
        wr_io(32'h90, 32'hFF12_3456);
        checks++; if (hex0 !== 7'b0000010) begin failures++; $display("FAIL hex0_six got=%b exp=%b", hex0, 7'b0000010); end
        checks++; if (hex1 !== 7'b0010010) begin failures++; $display("FAIL hex1_five got=%b exp=%b", hex1, 7'b0010010); end
        checks++; if (hex5 !== 7'b1111001) begin failures++; $display("FAIL hex5_one got=%b exp=%b", hex5, 7'b1111001); end
        rd(32'h90, rv);
        checks++; if (rv !== 32'h0012_3456) begin failures++; $display("FAIL hex_read got=%h exp=%h", rv, 32'h0012_3456); end
    endtask

    task automatic test_sw;
        sw = 10'h155;
        cyc(1);
        rd(32'h80, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL sw_one_edge got=%h exp=%h", rv, 32'h0); end
        cyc(1);
        rd(32'h80, rv);
        checks++; if (rv !== 32'h155) begin failures++; $display("FAIL sw_two_edges got=%h exp=%h", rv, 32'h155); end
        wr_io(32'h80, 32'hFFFF_FFFF);
        rd(32'h80, rv);
        checks++; if (rv !== 32'h155) begin failures++; $display("FAIL sw_readonly got=%h exp=%h", rv, 32'h155); end
    endtask

    task automatic test_keys;
        cyc(4);
        key = 4'b1011;
        cyc(2);
        rd(32'h84, rv);
        checks++; if (rv !== 32'h4) begin failures++; $display("FAIL key_level got=%h exp=%h", rv, 32'h4); end
        rd(32'h88, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL key_edge_early got=%h exp=%h", rv, 32'h0); end
        cyc(1);
        rd(32'h88, rv);
        checks++; if (rv !== 32'h4) begin failures++; $display("FAIL key_edge_set got=%h exp=%h", rv, 32'h4); end
        key = 4'b1010;
        cyc(2);
        wr_io(32'h88, 32'h4);
        rd(32'h88, rv);
        checks++; if (rv !== 32'h1) begin failures++; $display("FAIL w1c_other_bit got=%h exp=%h", rv, 32'h1); end
        key = 4'b1110;
        cyc(3);
        key = 4'b1010;
        cyc(2);
        wr_io(32'h88, 32'h4);
        rd(32'h88, rv);
        checks++; if (rv !== 32'h5) begin failures++; $display("FAIL w1c_set_wins got=%h exp=%h", rv, 32'h5); end
        wr_io(32'h88, 32'h5);
        rd(32'h88, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", rv, 32'h0); end
    endtask

    task automatic test_reset_mid_press;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(6);
        rd(32'h84, rv);
        checks++; if (rv !== 32'h5) begin failures++; $display("FAIL held_level got=%h exp=%h", rv, 32'h5); end
        rd(32'h88, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL held_no_edge got=%h exp=%h", rv, 32'h0); end
        checks++; if (led !== 10'h000) begin failures++; $display("FAIL held_led_reset got=%h exp=%h", led, 10'h000); end
        key = 4'hF;
        cyc(4);
        key = 4'b1110;
        cyc(3);
        rd(32'h88, rv);
        checks++; if (rv !== 32'h1) begin failures++; $display("FAIL repress_edge got=%h exp=%h", rv, 32'h1); end
    endtask

    task automatic test_debounce;
        logic moved;
        moved = 1'b0;
        cyc(4);
        key = 4'b1101;
        cyc(3);
        key = 4'hF;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            rd(32'h84, rv);
            if (rv !== 32'h0) moved = 1'b1;
        end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL glitch_level got=%b exp=%b", moved, 1'b0); end
        rd(32'h88, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL glitch_edge got=%h exp=%h", rv, 32'h0); end
        key = 4'b1101;
        cyc(9);
        rd(32'h84, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL deb_early got=%h exp=%h", rv, 32'h0); end
        cyc(1);
        rd(32'h84, rv);
        checks++; if (rv !== 32'h2) begin failures++; $display("FAIL deb_level got=%h exp=%h", rv, 32'h2); end
        cyc(1);
        rd(32'h88, rv);
        checks++; if (rv !== 32'h2) begin failures++; $display("FAIL deb_edge got=%h exp=%h", rv, 32'h2); end
        key = 4'hF;
    endtask

    task automatic test_ticks;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(100);
        rd(32'h94, rv);
        checks++; if (rv !== 32'd100) begin failures++; $display("FAIL ticks_100 got=%h exp=%h", rv, 32'd100); end
        wr_io(32'h94, 32'h1234);
        rd(32'h94, rv);
        checks++; if (rv !== 32'd0) begin failures++; $display("FAIL ticks_clear got=%h exp=%h", rv, 32'd0); end
        cyc(1);
        rd(32'h94, rv);
        checks++; if (rv !== 32'd1) begin failures++; $display("FAIL ticks_resume got=%h exp=%h", rv, 32'd1); end
        force dut.ticks = 32'hFFFF_FFFE;
        #1 release dut.ticks;
        cyc(1);
        rd(32'h94, rv);
        checks++; if (rv !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ticks_max got=%h exp=%h", rv, 32'hFFFF_FFFF); end
        cyc(1);
        rd(32'h94, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL ticks_wrap got=%h exp=%h", rv, 32'h0); end
        cyc(5);
        rst = 1'b1;
        rd(32'h94, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL ticks_async_rst got=%h exp=%h", rv, 32'h0); end
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw = '0;
        key = 4'hF;
        bus.mWriteMem = 1'b0;
        bus.mAlu = '0;
        bus.mDataB = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_led();
        test_hex();
        test_sw();
`ifdef PPL_IO_DEBOUNCE_EN
        test_debounce();
`else
        test_keys();
        test_reset_mid_press();
`endif
        test_ticks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
